alarm_controller_multi: RTL
===========================

Name: alarm_controller_multi

Overview:
- Parametrised successor to the single-alarm keypad controller FSM.
- Adds NUM_ALARMS selectable alarm registers, a configurable entry timeout and digit-count limit, and entry validation before any load.
- Adds a ring/buzzer supervisor with stop and auto-off.
- Sits between the keypad scanner/shift register, the time counter, the alarm registers and the display mux.

Parameters:
- NUM_ALARMS, 2, number of alarm registers (1..8).
- CH_W, 1, width of alarm channel index; must satisfy 2**CH_W >= NUM_ALARMS.
- TIMEOUT_SEC, 10, idle seconds in key entry before abort.
- NUM_DIGITS, 4, digits required for a complete HH:MM entry.
- RING_SEC, 60, seconds buzz stays on unless stopped.
- NO_KEY, 4'd10, keypad code meaning no key pressed.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- alarm_b  in  1  alarm button, level.
- time_b  in  1  time button, level.
- key  in  4  keypad code: 0-9 digit; NO_KEY idle; 11-15 treated as NO_KEY.
- one_sec  in  1  one-clk pulse per second.
- alarm_sel  in  CH_W  alarm channel selector.
- ring_req  in  NUM_ALARMS  per-alarm match level from comparators.
- stop_b  in  1  buzzer stop button, level.
- load_new_c  out  1  load shift register into time counter.
- load_new_a  out  NUM_ALARMS  one-hot load strobe to the selected alarm register.
- show_a  out  1  display alarm value.
- show_a_sel  out  CH_W  channel displayed or loaded (latched sel_q).
- show_c  out  1  display key-entry register.
- shift  out  1  shift current key into entry register.
- reset_counter  out  1  clear seconds prescaler on time set.
- digit_cnt  out  $clog2(NUM_DIGITS+1)  digits stored this entry.
- buzz  out  1  buzzer drive.

Behaviour:
- Reset (reset=0, async) sets state=SHOWTIME; clears tcnt, digit_cnt, sel_q, ring_cnt, buzz and ring_req_q. Every output is 0 during and after reset.
- valid_key = (key <= 9). All state outputs are Moore-decoded from registered state, giving one-cycle latency from input to output.
- show_a = SHOW_ALARM. load_new_c = reset_counter = SET_CT. load_new_a[sel_q] = SET_A; other bits are 0. shift = KEY_STORE. show_c = KEY_ENTRY|KEY_STORE|KEY_WAIT. show_a_sel = sel_q.
- SHOWTIME: alarm_b && alarm_sel<NUM_ALARMS -> SHOW_ALARM and latch sel_q=alarm_sel. Else valid_key -> KEY_STORE. Else stay. digit_cnt is cleared here.
- SHOW_ALARM: !alarm_b -> SHOWTIME; else stay. sel_q is held (alarm_sel changes are ignored).
- KEY_STORE: one cycle; digit_cnt++; tcnt cleared -> KEY_WAIT.
- KEY_WAIT: timeout -> SHOWTIME. Else !valid_key -> KEY_ENTRY. Else stay (key held).
- KEY_ENTRY, priority order:
  - timeout -> SHOWTIME.
  - alarm_b: if digit_cnt==NUM_DIGITS and alarm_sel<NUM_ALARMS, latch sel_q -> SET_A; otherwise -> SHOWTIME (abort).
  - time_b: if digit_cnt==NUM_DIGITS -> SET_CT; else -> SHOWTIME.
  - valid_key: if digit_cnt<NUM_DIGITS -> KEY_STORE; else -> KEY_WAIT (extra digit ignored, no shift).
  - otherwise stay.
- SET_A, SET_CT: one cycle -> SHOWTIME.
- Timeout counter tcnt, width $clog2(TIMEOUT_SEC):
  - Counts one_sec only in KEY_WAIT/KEY_ENTRY; cleared in all other states and in KEY_STORE.
  - timeout = one_sec && tcnt==TIMEOUT_SEC-1. The abort is therefore TIMEOUT_SEC pulses after the last stored key.
  - Simultaneous timeout and button/key: timeout wins.
- Ring supervisor, independent of main FSM:
  - ring_req_q registers ring_req; rise = ring_req & ~ring_req_q.
  - stop_b=1 -> buzz=0, ring_cnt=0. This has priority over a rise in the same cycle, which is lost.
  - Else any rise bit -> buzz=1, ring_cnt=0; a re-trigger while buzzing restarts the count.
  - Else buzz && one_sec -> ring_cnt++; at ring_cnt==RING_SEC-1 with one_sec, buzz=0.
  - A level held high does not re-trigger.
- Reset asserted mid-entry aborts immediately; no load strobe is emitted.

Test Plan:
- Reset release, idle key=10 for 100 cycles -> state SHOWTIME, all outputs 0, digit_cnt=0.
- Keys 1,2,3,0 (each held 3 clk, NO_KEY between), alarm_sel=1, alarm_b pulse -> four 1-clk shift pulses, digit_cnt=4, then load_new_a=2'b10 for exactly 1 clk, show_a_sel=1.
- Keys 0,7 then time_b -> no load_new_c; return to SHOWTIME, digit_cnt=0.
- Four keys then fifth key 9 -> shift pulses=4 only; time_b -> load_new_c=reset_counter=1 for 1 clk.
- One key, then 10 one_sec pulses with no key -> SHOWTIME after 10th pulse, show_c drops; with 9 pulses plus a key, entry continues.
- ring_req[0] rises -> buzz=1 next clk; 60 one_sec pulses -> buzz=0. Repeat with stop_b at pulse 5 -> buzz=0 next clk. stop_b and rise in same cycle -> buzz stays 0.

Source files
------------

// File: rtl/alarm_controller_multi_if.sv
`default_nettype none
// +-- alarm_controller_multi_if : keypad/button/ring inputs and display/load/buzzer outputs --+
// +-- rev 1.0                                                                               --+
interface alarm_controller_multi_if #(
  parameter int NUM_ALARMS = 2,
  parameter int CH_W       = 1,
  parameter int NUM_DIGITS = 4
);
  localparam int DIG_W = $clog2(NUM_DIGITS + 1);

  logic                  alarm_b;
  logic                  time_b;
  logic [3:0]            key;
  logic                  one_sec;
  logic [CH_W-1:0]       alarm_sel;
  logic [NUM_ALARMS-1:0] ring_req;
  logic                  stop_b;

  logic                  load_new_c;
  logic [NUM_ALARMS-1:0] load_new_a;
  logic                  show_a;
  logic [CH_W-1:0]       show_a_sel;
  logic                  show_c;
  logic                  shift;
  logic                  reset_counter;
  logic [DIG_W-1:0]      digit_cnt;
  logic                  buzz;

  modport master (
    output alarm_b, time_b, key, one_sec, alarm_sel, ring_req, stop_b,
    input  load_new_c, load_new_a, show_a, show_a_sel, show_c, shift,
           reset_counter, digit_cnt, buzz
  );

  modport slave (
    input  alarm_b, time_b, key, one_sec, alarm_sel, ring_req, stop_b,
    output load_new_c, load_new_a, show_a, show_a_sel, show_c, shift,
           reset_counter, digit_cnt, buzz
  );
endinterface
`default_nettype wire

// File: rtl/alarm_controller_multi.sv
`default_nettype none
// +-- alarm_controller_multi : keypad entry FSM with NUM_ALARMS alarm loads and buzzer supervisor --+
// +-- rev 1.0                                                                                    --+
module alarm_controller_multi #(
  parameter int         NUM_ALARMS  = 2,
  parameter int         CH_W        = 1,
  parameter int         TIMEOUT_SEC = 10,
  parameter int         NUM_DIGITS  = 4,
  parameter int         RING_SEC    = 60,
  parameter logic [3:0] NO_KEY      = 4'd10
) (
  input logic                   clk,
  input logic                   reset,
  alarm_controller_multi_if.slave bus
);
  localparam int DIG_W  = $clog2(NUM_DIGITS + 1);
  localparam int TCNT_W = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
  localparam int RCNT_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int SEL_W  = CH_W + 1;
  localparam logic [DIG_W-1:0]  C_FULL        = DIG_W'(NUM_DIGITS);
  localparam logic [TCNT_W-1:0] C_TMAX        = TCNT_W'(TIMEOUT_SEC - 1);
  localparam logic [RCNT_W-1:0] C_RMAX        = RCNT_W'(RING_SEC - 1);
  localparam logic [SEL_W-1:0]  C_NUM_ALARMS  = SEL_W'(NUM_ALARMS);

  typedef enum logic [2:0] {
    S_SHOWTIME   = 3'd0,
    S_SHOW_ALARM = 3'd1,
    S_KEY_STORE  = 3'd2,
    S_KEY_WAIT   = 3'd3,
    S_KEY_ENTRY  = 3'd4,
    S_SET_A      = 3'd5,
    S_SET_CT     = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CH_W-1:0]       r_sel;
  logic [CH_W-1:0]       w_sel_next;
  logic [DIG_W-1:0]      r_digit_cnt;
  logic [TCNT_W-1:0]     r_tcnt;
  logic                  r_show_a, r_load_c, r_shift, r_show_c;
  logic [NUM_ALARMS-1:0] r_load_a;
  logic [NUM_ALARMS-1:0] w_sel_dec;

  logic                  w_valid_key, w_sel_ok, w_full, w_in_entry, w_timeout;

  assign w_valid_key = (bus.key <= 4'd9) && (bus.key != NO_KEY);
  assign w_sel_ok    = {1'b0, bus.alarm_sel} < C_NUM_ALARMS;
  assign w_full      = (r_digit_cnt == C_FULL);
  assign w_in_entry  = (r_state == S_KEY_WAIT) || (r_state == S_KEY_ENTRY);
  assign w_timeout   = w_in_entry && bus.one_sec && (r_tcnt == C_TMAX);

  always_comb begin
    w_next     = r_state;
    w_sel_next = r_sel;
    case (r_state)
      S_SHOWTIME: begin
        if (bus.alarm_b && w_sel_ok) begin
          w_next     = S_SHOW_ALARM;
          w_sel_next = bus.alarm_sel;
        end else if (w_valid_key) begin
          w_next = S_KEY_STORE;
        end
      end
      S_SHOW_ALARM: if (!bus.alarm_b) w_next = S_SHOWTIME;
      S_KEY_STORE:  w_next = S_KEY_WAIT;
      S_KEY_WAIT: begin
        if (w_timeout)        w_next = S_SHOWTIME;
        else if (!w_valid_key) w_next = S_KEY_ENTRY;
      end
      // Priority: timeout, alarm button, time button, then further digits.
      S_KEY_ENTRY: begin
        if (w_timeout) begin
          w_next = S_SHOWTIME;
        end else if (bus.alarm_b) begin
          if (w_full && w_sel_ok) begin
            w_next     = S_SET_A;
            w_sel_next = bus.alarm_sel;
          end else begin
            w_next = S_SHOWTIME;
          end
        end else if (bus.time_b) begin
          w_next = w_full ? S_SET_CT : S_SHOWTIME;
        end else if (w_valid_key) begin
          w_next = w_full ? S_KEY_WAIT : S_KEY_STORE;
        end
      end
      default: w_next = S_SHOWTIME;
    endcase
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_sel_dec
    assign w_sel_dec[i] = (w_sel_next == CH_W'(i));
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SHOWTIME;
      r_sel       <= '0;
      r_digit_cnt <= '0;
      r_tcnt      <= '0;
      r_show_a    <= 1'b0;
      r_load_c    <= 1'b0;
      r_load_a    <= '0;
      r_shift     <= 1'b0;
      r_show_c    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sel    <= w_sel_next;
      r_show_a <= (w_next == S_SHOW_ALARM);
      r_load_c <= (w_next == S_SET_CT);
      r_load_a <= (w_next == S_SET_A) ? w_sel_dec : '0;
      r_shift  <= (w_next == S_KEY_STORE);
      r_show_c <= (w_next == S_KEY_ENTRY) || (w_next == S_KEY_STORE) ||
                  (w_next == S_KEY_WAIT);

      if (r_state == S_SHOWTIME)
        r_digit_cnt <= '0;
      else if (r_state == S_KEY_STORE)
        r_digit_cnt <= r_digit_cnt + DIG_W'(1);

      if (!w_in_entry || w_timeout)
        r_tcnt <= '0;
      else if (bus.one_sec)
        r_tcnt <= r_tcnt + TCNT_W'(1);
    end
  end

  logic [NUM_ALARMS-1:0] r_ring_req_q;
  logic [NUM_ALARMS-1:0] w_rise;
  logic [RCNT_W-1:0]     r_ring_cnt;
  logic                  r_buzz;

  assign w_rise = bus.ring_req & ~r_ring_req_q;

  // Stop wins over a simultaneous rise; a new rise while buzzing restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ring_req_q <= '0;
      r_ring_cnt   <= '0;
      r_buzz       <= 1'b0;
    end else begin
      r_ring_req_q <= bus.ring_req;
      if (bus.stop_b) begin
        r_buzz     <= 1'b0;
        r_ring_cnt <= '0;
      end else if (|w_rise) begin
        r_buzz     <= 1'b1;
        r_ring_cnt <= '0;
      end else if (r_buzz && bus.one_sec) begin
        if (r_ring_cnt == C_RMAX) begin
          r_buzz     <= 1'b0;
          r_ring_cnt <= '0;
        end else begin
          r_ring_cnt <= r_ring_cnt + RCNT_W'(1);
        end
      end
    end
  end

  assign bus.load_new_c    = r_load_c;
  assign bus.reset_counter = r_load_c;
  assign bus.load_new_a    = r_load_a;
  assign bus.show_a        = r_show_a;
  assign bus.show_a_sel    = r_sel;
  assign bus.show_c        = r_show_c;
  assign bus.shift         = r_shift;
  assign bus.digit_cnt     = r_digit_cnt;
  assign bus.buzz          = r_buzz;
endmodule
`default_nettype wire
